// File: rtl/count_ctrl_pkg.sv
// Shared command codes, FSM states and default widths for the counter controller.
package count_ctrl_pkg;

  localparam int unsigned PRESCALE_W_DEF = 8;
  localparam int unsigned WRAP_W_DEF     = 8;
  localparam int unsigned CMD_OP_W       = 2;

  typedef enum logic [CMD_OP_W-1:0] {
    CMD_START   = 2'b00,
    CMD_STOP    = 2'b01,
    CMD_CLEAR   = 2'b10,
    CMD_ONESHOT = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_ONESHOT = 2'b10,
    ST_CLR     = 2'b11
  } state_e;

endpackage

// File: rtl/count_ctrl_if.sv
// Command handshake plus downstream counter control/status bundle.
interface count_ctrl_if
  import count_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned WRAP_W     = WRAP_W_DEF
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_op_e               cmd_op;
  logic [PRESCALE_W-1:0] prescale;
  logic                  overflow;
  logic                  count_en;
  logic                  count_clr;
  logic                  busy;
  logic                  done;
  logic [WRAP_W-1:0]     wrap_cnt;

  // Controller side
  modport slave (
    input  cmd_valid, cmd_op, prescale, overflow,
    output cmd_ready, count_en, count_clr, busy, done, wrap_cnt
  );

  // Command source / counter side
  modport master (
    output cmd_valid, cmd_op, prescale, overflow,
    input  cmd_ready, count_en, count_clr, busy, done, wrap_cnt
  );

endinterface

// File: rtl/count_ctrl_prescaler.sv
// Programmable prescaler: ticks once every prescale_q+1 cycles while running.
module count_ctrl_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clr,
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [PRESCALE_W-1:0] r_prescale_q;
  logic                  w_at_top;

  assign w_at_top = (r_presc_cnt == r_prescale_q);

  // Ratio capture on START/ONESHOT; phase restarts on load, stop, clear or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc_cnt  <= '0;
      r_prescale_q <= '0;
    end else if (i_load) begin
      r_presc_cnt  <= '0;
      r_prescale_q <= i_prescale;
    end else if (i_clr || !i_run) begin
      r_presc_cnt  <= '0;
    end else if (w_at_top) begin
      r_presc_cnt  <= '0;
    end else begin
      r_presc_cnt  <= r_presc_cnt + PRESCALE_W'(1);
    end
  end

  // Tick decoded purely from flops so the accept cycle cannot suppress it
  assign o_tick = i_run && w_at_top;

endmodule

// File: rtl/count_ctrl.sv
// Command-driven controller for the 8-bit wrap counter: FSM, handshake,
// prescaled enable, saturating wrap-event count and oneshot completion pulse.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned WRAP_W     = WRAP_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  count_ctrl_if.slave bus
);

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [WRAP_W-1:0] r_wrap_cnt;

  logic w_ready;
  logic w_busy;
  logic w_accept;
  logic w_load;
  logic w_presc_clr;
  logic w_tick;
  logic w_wrap;

  assign w_ready     = (r_state != ST_CLR);
  assign w_busy      = (r_state == ST_RUN) || (r_state == ST_ONESHOT);
  assign w_accept    = bus.cmd_valid && w_ready;
  assign w_load      = w_accept && ((bus.cmd_op == CMD_START) || (bus.cmd_op == CMD_ONESHOT));
  assign w_presc_clr = w_accept && ((bus.cmd_op == CMD_STOP) || (bus.cmd_op == CMD_CLEAR));
  assign w_wrap      = w_tick && bus.overflow;

  count_ctrl_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_clr      (w_presc_clr),
    .i_run      (w_busy),
    .i_prescale (bus.prescale),
    .o_tick     (w_tick)
  );

  // State and done-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state; an accepted command always outranks oneshot completion
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ONESHOT: begin
        if (w_accept) begin
          case (bus.cmd_op)
            CMD_START:   w_state_nxt = ST_RUN;
            CMD_ONESHOT: w_state_nxt = ST_ONESHOT;
            CMD_STOP:    w_state_nxt = ST_IDLE;
            CMD_CLEAR:   w_state_nxt = ST_CLR;
            default:     w_state_nxt = r_state;
          endcase
        end else if ((r_state == ST_ONESHOT) && w_wrap) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_CLR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Saturating wrap-event counter, zeroed during the CLR cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap_cnt <= '0;
    end else if (r_state == ST_CLR) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap && (r_wrap_cnt != WRAP_MAX)) begin
      r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.count_en  = w_tick;
  assign bus.count_clr = (r_state == ST_CLR);
  assign bus.done      = r_done;
  assign bus.wrap_cnt  = r_wrap_cnt;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl driving a real 8-bit wrap counter, checked cycle by
// cycle against an elapsed-cycle reference model.
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_ONE  = 2;
  localparam int M_CLR  = 3;

  logic       clk;
  logic       rst;
  logic       cnt_rst;
  logic [7:0] r_count;

  count_ctrl_if #(.PRESCALE_W(8), .WRAP_W(8)) bus ();

  count_ctrl #(.PRESCALE_W(8), .WRAP_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8-bit wrap counter with its own reset
  always_ff @(posedge clk) begin
    if (cnt_rst)            r_count <= 8'd0;
    else if (bus.count_clr) r_count <= 8'd0;
    else if (bus.count_en)  r_count <= r_count + 8'd1;
  end
  assign bus.overflow = (r_count == 8'hFF);

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode, cycles elapsed since last load, ratio, wraps seen
  int m_mode  = M_IDLE;
  int m_k     = 0;
  int m_p     = 0;
  int m_wraps = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;
  bit m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with model, advance model
  task automatic step(input bit v, input cmd_op_e op, input int ps, input bit r);
    bit e_busy;
    bit e_en;
    bit e_clr;
    bit e_ready;
    bit wrap;
    bit acc;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.prescale  = 8'(ps);
    rst           = r;
    #1;
    e_busy  = (m_mode == M_RUN) || (m_mode == M_ONE);
    e_clr   = (m_mode == M_CLR);
    e_ready = !e_clr;
    e_en    = e_busy && ((m_k % (m_p + 1)) == m_p);
    if (m_known) begin
      chk("count_en",  32'(bus.count_en),  32'(e_en));
      chk("count_clr", 32'(bus.count_clr), 32'(e_clr));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
      chk("done",      32'(bus.done),      32'(m_done));
      chk("wrap_cnt",  32'(bus.wrap_cnt),  32'(m_wraps));
      chk("count",     32'(r_count),       32'(m_cnt));
    end
    wrap = e_en && (m_cnt == 255);
    acc  = v && e_ready;
    if (cnt_rst)    m_cnt = 0;
    else if (e_clr) m_cnt = 0;
    else if (e_en)  m_cnt = (m_cnt + 1) % 256;
    if (r) begin
      m_mode = M_IDLE; m_k = 0; m_p = 0; m_wraps = 0; m_done = 1'b0; m_known = 1'b1;
    end else begin
      if (e_clr) m_wraps = 0;
      else if (wrap && (m_wraps < 255)) m_wraps++;
      m_done = 1'b0;
      if (acc) begin
        case (op)
          CMD_START:   begin m_mode = M_RUN; m_p = ps; m_k = 0; end
          CMD_ONESHOT: begin m_mode = M_ONE; m_p = ps; m_k = 0; end
          CMD_STOP:    m_mode = M_IDLE;
          default:     m_mode = M_CLR;
        endcase
      end else if (m_mode == M_CLR) begin
        m_mode = M_IDLE;
      end else if ((m_mode == M_ONE) && wrap) begin
        m_mode = M_IDLE;
        m_done = 1'b1;
      end else if (e_busy) begin
        m_k++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, CMD_STOP, 0, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    cnt_rst       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = CMD_STOP;
    bus.prescale  = 8'd0;
    @(negedge clk);

    // Reset held two cycles
    step(1'b0, CMD_STOP, 0, 1'b1);
    step(1'b0, CMD_STOP, 0, 1'b1);
    cnt_rst = 1'b0;
    chk("rst_count_en",  32'(bus.count_en),  32'd0);
    chk("rst_count_clr", 32'(bus.count_clr), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_wrap_cnt",  32'(bus.wrap_cnt),  32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Free run at full rate: 256 enables wrap the counter once
    step(1'b1, CMD_START, 0, 1'b0);
    idle(256);
    chk("run0_count", 32'(r_count),      32'd0);
    chk("run0_wrap",  32'(bus.wrap_cnt), 32'd1);
    step(1'b1, CMD_STOP, 0, 1'b0);
    idle(1);

    // Clear back to a known counter value
    step(1'b1, CMD_CLEAR, 0, 1'b0);
    idle(2);
    chk("clr_count", 32'(r_count),      32'd0);
    chk("clr_wrap",  32'(bus.wrap_cnt), 32'd0);

    // Divide-by-4: enables at cycles 4,8,12 after accept
    step(1'b1, CMD_START, 3, 1'b0);
    idle(12);
    chk("div4_count", 32'(r_count), 32'd3);
    idle(3);
    step(1'b1, CMD_STOP, 7, 1'b0);
    chk("stop_on_en_count", 32'(r_count),  32'd4);
    chk("stop_busy",        32'(bus.busy), 32'd0);

    // Oneshot from zero completes after 256 enables
    step(1'b1, CMD_CLEAR, 0, 1'b0);
    idle(1);
    step(1'b1, CMD_ONESHOT, 0, 1'b0);
    idle(256);
    chk("one_done",  32'(bus.done),     32'd1);
    chk("one_busy",  32'(bus.busy),     32'd0);
    chk("one_count", 32'(r_count),      32'd0);
    chk("one_wrap",  32'(bus.wrap_cnt), 32'd1);
    idle(1);
    chk("one_done_pulse", 32'(bus.done), 32'd0);

    // Clear while running at count 0x40; commands blocked during CLR
    step(1'b1, CMD_START, 0, 1'b0);
    idle(64);
    chk("pre_clr_count", 32'(r_count), 32'h40);
    step(1'b1, CMD_CLEAR, 0, 1'b0);
    chk("clr_ready", 32'(bus.cmd_ready), 32'd0);
    chk("clr_pulse", 32'(bus.count_clr), 32'd1);
    step(1'b1, CMD_START, 0, 1'b0);
    chk("post_clr_count", 32'(r_count),       32'd0);
    chk("post_clr_wrap",  32'(bus.wrap_cnt),  32'd0);
    chk("post_clr_busy",  32'(bus.busy),      32'd0);
    chk("post_clr_ready", 32'(bus.cmd_ready), 32'd1);
    step(1'b1, CMD_STOP, 0, 1'b0);
    chk("stop_idle_busy",  32'(bus.busy), 32'd0);
    chk("stop_idle_count", 32'(r_count),  32'd0);

    // STOP on the wrapping enable still counts the wrap
    step(1'b1, CMD_START, 0, 1'b0);
    idle(255);
    step(1'b1, CMD_STOP, 0, 1'b0);
    chk("stop_wrap_cnt", 32'(bus.wrap_cnt), 32'd1);

    // STOP coinciding with oneshot completion suppresses done
    step(1'b1, CMD_ONESHOT, 0, 1'b0);
    idle(255);
    step(1'b1, CMD_STOP, 0, 1'b0);
    chk("supp_done", 32'(bus.done),     32'd0);
    chk("supp_wrap", 32'(bus.wrap_cnt), 32'd2);

    // Reset in the middle of a oneshot
    step(1'b1, CMD_ONESHOT, 1, 1'b0);
    idle(10);
    step(1'b0, CMD_STOP, 0, 1'b1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    idle(300);

    // Random command traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 31) == 0), cmd_op_e'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), ($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
